// File: rtl/instr_fetch.sv
`default_nettype none
// =============================================================================
// Module : instr_fetch
// Fetch initiator: PC, instruction-memory read, PC-tagged FIFO to decode,
// redirect flush and out-of-range fault.
// Rev    : 1.0
// =============================================================================
module instr_fetch #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       MEM_DEPTH = 8192,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_enbl,
  output logic              imem_wrt_enbl,
  output logic [DATA_W-1:0] imem_dat_in,
  input  logic [DATA_W-1:0] imem_dat_out,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_fault
);

  localparam int unsigned       c_ptr_w     = $clog2(BUF_DEPTH);
  localparam logic [ADDR_W:0]   c_mem_depth = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [c_ptr_w:0]  c_buf_depth = (c_ptr_w+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_fault;
  logic [ADDR_W-1:0]   r_pc;
  logic [c_ptr_w-1:0]  r_wptr;
  logic [c_ptr_w-1:0]  r_rptr;
  logic [c_ptr_w:0]    r_count;
  logic [DATA_W-1:0]   r_buf_instr [BUF_DEPTH];
  logic [ADDR_W-1:0]   r_buf_pc    [BUF_DEPTH];

  logic w_pc_ok;
  logic w_redir_ok;
  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_push;

  // Range checks are done one bit wider so MEM_DEPTH == 2**ADDR_W still works.
  assign w_pc_ok    = ({1'b0, r_pc} < c_mem_depth);
  assign w_redir_ok = ({1'b0, redir_pc} < c_mem_depth);
  assign w_full     = (r_count == c_buf_depth);
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && instr_ready;
  assign w_push     = (r_state == S_FETCH) && w_pc_ok && (!w_full || w_pop) && !redir_valid;

  assign imem_addr     = r_pc;
  assign imem_rd_enbl  = w_push;
  assign imem_wrt_enbl = 1'b0;
  assign imem_dat_in   = '0;
  assign instr_valid   = w_valid;
  assign instr         = w_valid ? r_buf_instr[r_rptr] : '0;
  assign instr_pc      = w_valid ? r_buf_pc[r_rptr]    : '0;
  assign fetch_fault   = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fetch_en) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (!fetch_en) begin
            r_state <= S_IDLE;
          end else if (!redir_valid && !w_pc_ok) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end
        end
        S_FAULT: begin
          if (redir_valid && w_redir_ok) begin
            r_fault <= 1'b0;
            r_state <= fetch_en ? S_FETCH : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A redirect flushes the FIFO and overrides any pop bookkeeping that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redir_valid) begin
      r_pc    <= redir_pc;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + ADDR_W'(1);
        r_wptr <= r_wptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_w'(1);
      end
      r_count <= r_count + (c_ptr_w+1)'(w_push) - (c_ptr_w+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wptr] <= imem_dat_out;
      r_buf_pc[r_wptr]    <= r_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// Bench for instr_fetch: directed vector table plus hand-written sequences
// for fetch-enable drain/resume and asynchronous reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic        imem_rd_enbl;
  logic        imem_wrt_enbl;
  logic [31:0] imem_dat_in;
  logic [31:0] imem_dat_out;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  logic [31:0] mem [0:8191];

  always #5 clk = ~clk;

  assign imem_dat_out = (imem_addr < 32'd8192) ? mem[imem_addr[12:0]] : 32'hDEAD_BEEF;

  instr_fetch #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'd0),
    .MEM_DEPTH(8192),
    .BUF_DEPTH(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_en     (fetch_en),
    .imem_addr    (imem_addr),
    .imem_rd_enbl (imem_rd_enbl),
    .imem_wrt_enbl(imem_wrt_enbl),
    .imem_dat_in  (imem_dat_in),
    .imem_dat_out (imem_dat_out),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .fetch_fault  (fetch_fault)
  );

  typedef struct {
    logic        rst_n;
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic        erd;
    logic [31:0] eaddr;
    logic        eflt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic r, input logic fe, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                              input logic erd, input logic [31:0] eaddr, input logic eflt);
    vec_t v;
    v.rst_n = r;  v.fe = fe;   v.rdy = rdy;     v.rv = rv;   v.rpc = rpc;
    v.ev    = ev; v.epc = epc; v.erd = erd;     v.eaddr = eaddr; v.eflt = eflt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_next;
    logic [31:0] frozen;
    logic [31:0] exp_instr;
    logic [31:0] exp_ipc;
    bit          found;
    int          n_del;

    for (int i = 0; i < 8192; i++) mem[i] = 32'hC0DE_0000 ^ 32'(i);
    mem[0] = 32'h0062_0800;
    mem[1] = 32'h00C5_2000;
    mem[2] = 32'h0081_0801;

    rst_n = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0;
    repeat (2) @(posedge clk);

    //               rst fe rdy rv rpc       ev epc      rd addr     flt
    tbl.push_back(mk(0, 1, 1, 0, 0,        0, 0,       0, 0,       0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        0, 0,       0, 0,       0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        0, 0,       1, 0,       0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        1, 0,       1, 1,       0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        1, 1,       1, 2,       0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        1, 2,       1, 3,       0));
    tbl.push_back(mk(0, 1, 0, 0, 0,        0, 0,       0, 0,       0));
    tbl.push_back(mk(1, 1, 0, 0, 0,        0, 0,       0, 0,       0));
    tbl.push_back(mk(1, 1, 0, 0, 0,        0, 0,       1, 0,       0));
    tbl.push_back(mk(1, 1, 0, 0, 0,        1, 0,       1, 1,       0));
    tbl.push_back(mk(1, 1, 0, 0, 0,        1, 0,       0, 2,       0));
    tbl.push_back(mk(1, 1, 0, 0, 0,        1, 0,       0, 2,       0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        1, 0,       1, 2,       0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        1, 1,       1, 3,       0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        1, 2,       1, 4,       0));
    tbl.push_back(mk(1, 1, 0, 1, 5,        1, 3,       0, 5,       0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        0, 0,       1, 5,       0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        1, 5,       1, 6,       0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        1, 6,       1, 7,       0));
    tbl.push_back(mk(1, 1, 1, 1, 8190,     1, 7,       0, 8,       0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        0, 0,       1, 8190,    0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        1, 8190,    1, 8191,    0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        1, 8191,    0, 8192,    0));
    tbl.push_back(mk(1, 1, 1, 1, 9000,     0, 0,       0, 8192,    1));
    tbl.push_back(mk(1, 1, 1, 0, 0,        0, 0,       0, 9000,    1));
    tbl.push_back(mk(1, 1, 1, 1, 0,        0, 0,       0, 9000,    1));
    tbl.push_back(mk(1, 1, 1, 0, 0,        0, 0,       1, 0,       0));
    tbl.push_back(mk(1, 1, 1, 0, 0,        1, 0,       1, 1,       0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n       = tbl[i].rst_n;
      fetch_en    = tbl[i].fe;
      instr_ready = tbl[i].rdy;
      redir_valid = tbl[i].rv;
      redir_pc    = tbl[i].rpc;
      #1;
      n_vec++;
      exp_ipc   = tbl[i].ev ? tbl[i].epc : 32'd0;
      exp_instr = tbl[i].ev ? mem[exp_ipc[12:0]] : 32'd0;
      chk("instr_valid", i, 64'(instr_valid),   64'(tbl[i].ev));
      chk("instr_pc",    i, 64'(instr_pc),      64'(exp_ipc));
      chk("instr",       i, 64'(instr),         64'(exp_instr));
      chk("imem_rd",     i, 64'(imem_rd_enbl),  64'(tbl[i].erd));
      chk("imem_addr",   i, 64'(imem_addr),     64'(tbl[i].eaddr));
      chk("fetch_fault", i, 64'(fetch_fault),   64'(tbl[i].eflt));
      chk("imem_wr",     i, 64'(imem_wrt_enbl), 64'(0));
      chk("imem_din",    i, 64'(imem_dat_in),   64'(0));
    end

    // Drop fetch_en mid-stream: PC freezes, FIFO drains.
    exp_next = 32'd1;
    frozen   = 32'd0;
    @(negedge clk);
    redir_valid = 1'b0; fetch_en = 1'b0; instr_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (instr_valid) begin
        n_vec++;
        chk("drain_pc",    c, 64'(instr_pc), 64'(exp_next));
        chk("drain_instr", c, 64'(instr),    64'(mem[exp_next[12:0]]));
        exp_next++;
      end
      if (c == 2) frozen = imem_addr;
      if (c > 2) begin
        n_vec++;
        chk("frozen_pc", c, 64'(imem_addr), 64'(frozen));
      end
    end
    n_vec++;
    chk("drain_empty", 0, 64'(instr_valid), 64'(0));
    chk("frozen_next", 0, 64'(frozen),      64'(exp_next));

    // Re-enable: delivery resumes at the frozen PC with no gap in PCs.
    n_del = 0;
    @(negedge clk);
    fetch_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (instr_valid) begin
        n_vec++;
        chk("resume_pc",    c, 64'(instr_pc), 64'(exp_next));
        chk("resume_instr", c, 64'(instr),    64'(mem[exp_next[12:0]]));
        exp_next++;
        n_del++;
      end
    end
    n_vec++;
    chk("resume_count", 0, 64'(n_del >= 5), 64'(1));

    // Fill the FIFO, then reset asynchronously between clock edges.
    @(negedge clk);
    instr_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (instr_valid && !imem_rd_enbl) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    chk("fill_full", 0, 64'(found), 64'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    chk("arst_valid", 0, 64'(instr_valid), 64'(0));
    chk("arst_pc",    0, 64'(imem_addr),   64'(0));
    chk("arst_fault", 0, 64'(fetch_fault), 64'(0));
    chk("arst_rd",    0, 64'(imem_rd_enbl), 64'(0));

    @(negedge clk);
    rst_n = 1'b1; instr_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    chk("refetch_seen",  0, 64'(found),    64'(1));
    chk("refetch_pc",    0, 64'(instr_pc), 64'(0));
    chk("refetch_instr", 0, 64'(instr),    64'(mem[0]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
